// File: rtl/int_to_fp_converter.sv
// int_to_fp_converter
//   Sequential two's-complement integer to IEEE-style single-precision float
//   converter. It shifts one leading zero out per cycle, spends one cycle
//   rounding (round-to-nearest-even), and then holds the result until the
//   consumer accepts it. Only one conversion is in flight at a time.
//
//   Optional build macro: INT_TO_FP_FAST_NORM_EN
//     When defined, NORM shifts by 8 in a single cycle whenever the top 8
//     magnitude bits are all zero. Results are bit-identical to the default
//     build; only the latency changes.
//
//   Ports:
//     clk          clock, rising edge
//     reset        synchronous active-high reset
//     in_valid     in_int is valid
//     in_ready     converter can accept an input (IDLE only)
//     in_int       signed integer operand, INT_WIDTH bits
//     out_valid    out_fp / out_inexact are valid
//     out_ready    downstream accepts the result
//     out_fp       packed {sign, exp, frac}
//     out_inexact  discarded bits were non-zero
module int_to_fp_converter #(
  parameter int unsigned INT_WIDTH     = 32,
  parameter int unsigned EXPONENT_BITS = 8,
  parameter int unsigned FRACTION_BITS = 23
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [INT_WIDTH-1:0]                     in_int,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [EXPONENT_BITS+FRACTION_BITS:0]     out_fp,
  output logic                                     out_inexact
);

  localparam int unsigned FP_WIDTH  = 1 + EXPONENT_BITS + FRACTION_BITS;
  // Bits of the normalised magnitude below the guard bit (sticky region).
  localparam int unsigned LOW_BITS  = INT_WIDTH - 2 - FRACTION_BITS;
  localparam int unsigned BIAS      = (1 << (EXPONENT_BITS - 1)) - 1;
  localparam logic [EXPONENT_BITS-1:0] EXP_INIT =
    EXPONENT_BITS'(BIAS + INT_WIDTH - 1);
  localparam logic [INT_WIDTH-1:0] LOW_MASK =
    (INT_WIDTH'(1) << LOW_BITS) - INT_WIDTH'(1);
`ifdef INT_TO_FP_FAST_NORM_EN
  localparam int unsigned FAST_STEP = 8;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [INT_WIDTH-1:0]         mag_q, mag_d;
  logic [EXPONENT_BITS-1:0]     exp_q, exp_d;
  logic                         sign_q, sign_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic [FP_WIDTH-1:0]          out_fp_q, out_fp_d;
  logic                         out_inexact_q, out_inexact_d;

  // Rounding datapath, evaluated from the normalised magnitude.
  logic [FRACTION_BITS-1:0]     frac_trunc;
  logic [FRACTION_BITS:0]       frac_sum;
  logic                         guard_bit;
  logic                         sticky_bit;
  logic                         round_up;
  logic [FRACTION_BITS-1:0]     frac_rnd;
  logic [EXPONENT_BITS-1:0]     exp_rnd;

  assign frac_trunc = mag_q[INT_WIDTH-2 -: FRACTION_BITS];
  assign guard_bit  = mag_q[LOW_BITS];
  assign sticky_bit = |(mag_q & LOW_MASK);
  assign round_up   = guard_bit & (sticky_bit | frac_trunc[0]);
  assign frac_sum   = {1'b0, frac_trunc} + (FRACTION_BITS+1)'(1);
  assign frac_rnd   = round_up ? frac_sum[FRACTION_BITS-1:0] : frac_trunc;
  // A carry out of the fraction means the mantissa rolled over to 1.0 x 2^(e+1).
  assign exp_rnd    = (round_up && frac_sum[FRACTION_BITS])
                      ? exp_q + EXPONENT_BITS'(1) : exp_q;

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    mag_d         = mag_q;
    exp_d         = exp_q;
    sign_d        = sign_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_fp_d      = out_fp_q;
    out_inexact_d = out_inexact_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d     = in_int[INT_WIDTH-1];
          // Negation wraps the most negative input onto 2^(INT_WIDTH-1), which is its magnitude.
          mag_d      = in_int[INT_WIDTH-1] ? (~in_int + INT_WIDTH'(1)) : in_int;
          exp_d      = EXP_INIT;
          in_ready_d = 1'b0;
          if (in_int == '0) begin
            state_d       = DONE;
            out_fp_d      = '0;
            out_inexact_d = 1'b0;
            out_valid_d   = 1'b1;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        if (mag_q[INT_WIDTH-1]) begin
          state_d = ROUND;
`ifdef INT_TO_FP_FAST_NORM_EN
        end else if (mag_q[INT_WIDTH-1 -: FAST_STEP] == '0) begin
          mag_d = mag_q << FAST_STEP;
          exp_d = exp_q - EXPONENT_BITS'(FAST_STEP);
`endif
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXPONENT_BITS'(1);
        end
      end

      ROUND: begin
        exp_d         = exp_rnd;
        out_fp_d      = {sign_q, exp_rnd, frac_rnd};
        out_inexact_d = guard_bit | sticky_bit;
        out_valid_d   = 1'b1;
        state_d       = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mag_q         <= '0;
      exp_q         <= '0;
      sign_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_fp_q      <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mag_q         <= mag_d;
      exp_q         <= exp_d;
      sign_q        <= sign_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_fp_q      <= out_fp_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_fp      = out_fp_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_fp_converter.sv
// tb_int_to_fp_converter
//   Directed-vector bench for int_to_fp_converter at default parameters.
//   Expected results are hand-computed IEEE single-precision encodings.
module tb_int_to_fp_converter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_int;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fp;
  logic        out_inexact;

  int checks;
  int errors;

  int_to_fp_converter dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_int      (in_int),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fp      (out_fp),
    .out_inexact (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Edges from acceptance to out_valid for a non-zero input with lz leading zeros.
  function automatic int lat_for(input int lz);
`ifdef INT_TO_FP_FAST_NORM_EN
    return (lz / 8) + (lz % 8) + 3;
`else
    return lz + 3;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion with out_ready held high.
  task automatic do_conv(input string tag, input logic [31:0] v,
                         input logic [31:0] efp, input logic einx, input int elat);
    int edges;
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_int   = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_int   = 32'hDEAD_BEEF;
    edges    = 1;
    while (!out_valid && edges < 200) begin
      tick();
      edges++;
    end
    check_eq({tag, "_lat"}, 32'(edges), 32'(elat));
    check_eq({tag, "_fp"}, out_fp, efp);
    check_eq({tag, "_inexact"}, 32'(out_inexact), 32'(einx));
    tick();
    check_eq({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int edges;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_int    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_fp", out_fp, 32'h0);
    check_eq("rst_inexact", 32'(out_inexact), 32'd0);

    do_conv("one",      32'h0000_0001, 32'h3F80_0000, 1'b0, lat_for(31));
    do_conv("neg_one",  32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, lat_for(31));
    do_conv("zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 1);
    do_conv("int_min",  32'h8000_0000, 32'hCF00_0000, 1'b0, lat_for(0));
    do_conv("int_max",  32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, lat_for(1));
    do_conv("tie_even", 32'd16777217,  32'h4B80_0000, 1'b1, lat_for(7));
    do_conv("tie_up",   32'd16777219,  32'h4B80_0002, 1'b1, lat_for(7));
    do_conv("exact24",  32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0, lat_for(8));
    do_conv("neg100",   32'hFFFF_FF9C, 32'hC2C8_0000, 1'b0, lat_for(25));
    do_conv("three",    32'd3,         32'h4040_0000, 1'b0, lat_for(30));

    // Backpressure: result must hold and a stray input must be ignored.
    out_ready = 1'b0;
    in_int    = 32'd100;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    edges     = 1;
    while (!out_valid && edges < 200) begin
      tick();
      edges++;
    end
    check_eq("bp_lat", 32'(edges), 32'(lat_for(25)));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_int   = 32'd5;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      check_eq("bp_hold_fp", out_fp, 32'h42C8_0000);
      check_eq("bp_hold_vld", 32'(out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    check_eq("bp_hold_fp_end", out_fp, 32'h42C8_0000);
    out_ready = 1'b1;
    tick();
    check_eq("bp_vld_drop", 32'(out_valid), 32'd0);
    check_eq("bp_rdy_back", 32'(in_ready), 32'd1);
    tick();
    check_eq("bp_stray_ignored", 32'(out_valid), 32'd0);

    // Reset mid-NORM discards the in-flight conversion.
    in_int   = 32'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("mid_norm_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_vld", 32'(out_valid), 32'd0);
    check_eq("mid_rst_rdy", 32'(in_ready), 32'd1);
    check_eq("mid_rst_fp", out_fp, 32'h0);
    do_conv("two", 32'd2, 32'h4000_0000, 1'b0, lat_for(30));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_to_fp_converter.md
Name: int_to_fp_converter

Overview:
- Sequential signed-integer to single-precision float converter. It sits directly upstream of the float consumers in the floating-point block set and produces the same {sign, exp, frac} packed layout they take in.
- Normalisation uses an iterative shift FSM: one leading-zero step per cycle, then one rounding cycle (round-to-nearest-even).
- Valid/ready handshake on both sides.
- Processes one conversion at a time; no pipelining.

Parameters:
- INT_WIDTH, 32, width of the two's-complement input integer; must exceed FRACTION_BITS+1.
- EXPONENT_BITS, 8, exponent field width of the output.
- FRACTION_BITS, 23, fraction field width of the output.
- The bias is fixed at 2^(EXPONENT_BITS-1)-1 (127 at defaults).

Ports:
- clk  in  1  clock. Every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_int is valid.
- in_ready  out  1  converter can accept an input.
- in_int  in  INT_WIDTH  signed integer operand.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- out_fp  out  1+EXPONENT_BITS+FRACTION_BITS  packed {sign, exp, frac}.
- out_inexact  out  1  result was rounded (discarded bits were non-zero).

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - in_ready=1, out_valid=0, out_fp=0, out_inexact=0.
  - Internal magnitude, exponent and sign registers are cleared.
- States: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1 only in this state.
  - On in_valid && in_ready:
    - Latch sign = in_int MSB.
    - Latch mag = |in_int| as an unsigned INT_WIDTH value. The most negative input gives mag = 2^(INT_WIDTH-1) with no overflow.
    - Latch exp = bias + INT_WIDTH - 1 (158 at defaults).
  - If in_int == 0: go to DONE with out_fp = all zeros (+0) and out_inexact = 0.
  - Otherwise go to NORM.
- NORM, one decision per cycle:
  - If mag MSB == 1: go to ROUND; no shift this cycle.
  - Else: mag <<= 1, exp -= 1, stay in NORM.
  - Time in NORM = lz+1 cycles, where lz = leading zeros of the magnitude.
- ROUND, single cycle:
  - frac = mag[INT_WIDTH-2 -: FRACTION_BITS].
  - guard = the next bit below frac.
  - sticky = OR of all remaining lower bits.
  - round_up = guard && (sticky || frac LSB).
  - If round_up, frac += 1. If frac wraps to 0, exp += 1.
  - out_inexact = guard || sticky.
  - Register out_fp = {sign, exp, frac}, then go to DONE.
- DONE:
  - out_valid=1.
  - out_fp and out_inexact are held stable until out_ready is sampled high.
  - On out_valid && out_ready: go to IDLE and drop out_valid. A new input is accepted at the earliest on the following cycle; there is no same-cycle turnaround.
- Latency (edges from input acceptance to out_valid high):
  - Non-zero input: lz+3.
  - Zero input: 1.
- Boundaries:
  - Exponent overflow is impossible at defaults. The largest result is 0x4F000000 (from 0x7FFFFFFF after rounding), and the exponent never exceeds 158.
  - Denormal, NaN and infinity outputs are never generated.
  - in_valid in any state other than IDLE is ignored; in_int is not required to be held.
  - out_ready while out_valid=0 has no effect.
  - reset asserted in any state, including mid-NORM or while DONE is stalled, aborts the conversion. All reset values apply on the next edge and the in-flight result is discarded.

Optional Feature:
- Macro: INT_TO_FP_FAST_NORM_EN.
- When defined: in NORM, if the top 8 bits of mag are all zero, mag <<= 8 and exp -= 8 in one cycle; otherwise the 1-bit rule applies.
  - Latency = floor(lz/8) + (lz mod 8) + 3.
  - Results are bit-identical to the undefined build.
- When undefined: 1-bit shift only, latency lz+3.

Test Plan:
- Input 1, out_ready held 1 → out_fp=0x3F800000, inexact=0, out_valid after 34 edges (with fast-norm: 3+7+3=13).
- Input -1 → 0xBF800000; input 0 → 0x00000000 after 1 edge, inexact=0.
- Input 0x80000000 (-2^31) → 0xCF000000, inexact=0, latency 3. Input 0x7FFFFFFF → 0x4F000000, inexact=1 (exponent bumped on frac wrap).
- Rounding ties:
  - 16777217 → 0x4B800000, inexact=1 (tie, round to even, down).
  - 16777219 → 0x4B800002, inexact=1 (tie, round up).
- Backpressure: input 100 with out_ready=0 for 5 cycles after out_valid → out_fp stays 0x42C80000 and out_valid stays 1. in_ready stays 0 and a second in_valid pulse is ignored. The handshake completes on the first out_ready=1 cycle and in_ready returns to 1 on the next edge.
- Reset mid-NORM: input 1, assert reset 5 cycles after acceptance → next edge gives out_valid=0, in_ready=1, out_fp=0. A subsequent input 2 converts to 0x40000000.
